mem_req_queue: RTL and testbench

Request-side front end for the `memory` stage (direct-mapped cache over RAM). It accepts read/write requests from the processor side through a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time on `memory`'s `address`/`data`/`mode` inputs, holding each for exactly the cycles `memory` needs. It then captures `out` for reads and returns the read data through a valid/ready response port.

---
 rtl/mem_req_queue.sv | 145 ++++++++++++++
 tb/tb_mem_req_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// mem_req_queue: request FIFO and sequencer in front of the memory stage.
// Requests are buffered, issued one at a time on registered mem_* lines
// that are held between issues, and read data comes back on a
// valid/ready response port in strict request order.
module mem_req_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // request side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    // memory stage interface
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_mode,
    input  logic [DATA_W-1:0] mem_out,
    // status
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic              mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    req_t             fifo_mem [DEPTH];
    req_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    state_t           state;
    logic             push;
    logic             pop;

    assign head = fifo_mem[rd_ptr];
    assign push = req_valid && req_ready;
    assign pop  = (state == IDLE) && (count != '0);
    assign busy = (count != '0) || (state != IDLE);

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Entry storage; no reset needed since only written slots are ever popped.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{mode: req_mode, addr: req_addr, wdata: req_wdata};
        end
    end

    // Pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_nxt;
            req_ready <= (count_nxt != FULL_CNT);
        end
    end

    // Issue sequencer: mem_* change only on a pop and are held otherwise,
    // since the memory stage reacts only to a change on its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_address <= '0;
            mem_data    <= '0;
            mem_mode    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        mem_address <= head.addr;
                        mem_mode    <= head.mode;
                        // reads leave the data lines untouched
                        if (head.mode) begin
                            mem_data <= head.wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // memory samples the new inputs at the edge closing this cycle
                    state <= mem_mode ? IDLE : CAPTURE;
                end
                CAPTURE: begin
                    rsp_data  <= mem_out;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue with a behavioural memory-stage model.
module tb_mem_req_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_mode;
    logic [31:0] mem_out = '0;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // memory stage model: acts only when its inputs differ from the previous ones
    logic [31:0] ram [256] = '{default: 32'h0};
    logic        p_mode = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;

    always @(posedge clk) begin
        if ({mem_mode, mem_address, mem_data} !== {p_mode, p_addr, p_data}) begin
            p_mode <= mem_mode;
            p_addr <= mem_address;
            p_data <= mem_data;
            if (mem_mode) ram[mem_address[7:0]] <= mem_data;
            else          mem_out <= ram[mem_address[7:0]];
        end
    end

    always #5 clk = ~clk;

    mem_req_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_mode    (mem_mode),
        .mem_out     (mem_out),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic mode, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    logic [31:0] drain_exp [5];

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_mode  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // reset
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_mem_mode", 32'(mem_mode), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // write then read back-to-back
        rsp_ready = 1'b1;
        push(1'b1, 32'h10, 32'hDEADBEEF);               // E0
        chk("wr_mode_pre", 32'(mem_mode), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        push(1'b0, 32'h10, 32'h0);                      // E1
        chk("wr_mode_c1", 32'(mem_mode), 32'd1);
        chk("wr_addr", mem_address, 32'h10);
        chk("wr_data", mem_data, 32'hDEADBEEF);
        step();                                         // E2
        chk("wr_mode_c2", 32'(mem_mode), 32'd1);
        step();                                         // E3: read popped
        chk("wr_mode_end", 32'(mem_mode), 32'd0);
        chk("rd_addr", mem_address, 32'h10);
        chk("rd_keeps_data", mem_data, 32'hDEADBEEF);
        step();                                         // E4
        chk("rd_valid_early", 32'(rsp_valid), 32'd0);
        step();                                         // E5
        chk("rd_valid", 32'(rsp_valid), 32'd1);
        chk("rd_data", rsp_data, 32'hDEADBEEF);
        step();                                         // E6
        chk("rd_valid_drop", 32'(rsp_valid), 32'd0);
        chk("rd_busy_done", 32'(busy), 32'd0);

        // identical back-to-back reads
        push(1'b1, 32'h20, 32'h55);
        wait_idle();
        push(1'b0, 32'h20, 32'h0);                      // E
        push(1'b0, 32'h20, 32'h0);                      // E+1
        step();                                         // E+2
        chk("idr_valid_early", 32'(rsp_valid), 32'd0);
        step();                                         // E+3
        chk("idr1_valid", 32'(rsp_valid), 32'd1);
        chk("idr1_data", rsp_data, 32'h55);
        step();                                         // E+4
        chk("idr1_drop", 32'(rsp_valid), 32'd0);
        step();
        step();
        step();                                         // E+7
        chk("idr2_valid", 32'(rsp_valid), 32'd1);
        chk("idr2_data", rsp_data, 32'h55);
        chk("idr2_mem_data", mem_data, 32'h55);
        wait_idle();

        // response backpressure holds the pipeline
        push(1'b1, 32'h30, 32'h1234);
        wait_idle();
        rsp_ready = 1'b0;
        push(1'b0, 32'h30, 32'h0);                      // E
        push(1'b1, 32'h40, 32'h99);                     // E+1
        step();
        step();                                         // E+3
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_data", rsp_data, 32'h1234);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_data", rsp_data, 32'h1234);
            chk("bp_hold_addr", mem_address, 32'h30);
            chk("bp_hold_mode", 32'(mem_mode), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_handshake", 32'(rsp_valid), 32'd0);
        step();
        chk("bp_next_mode", 32'(mem_mode), 32'd1);
        chk("bp_next_addr", mem_address, 32'h40);
        wait_idle();

        // full FIFO while stalled in RESP
        rsp_ready = 1'b0;
        push(1'b0, 32'h10, 32'h0);                      // popped, stalls in RESP
        push(1'b0, 32'h20, 32'h0);
        push(1'b0, 32'h30, 32'h0);
        chk("full_ready_2", 32'(req_ready), 32'd1);
        push(1'b0, 32'h40, 32'h0);
        chk("full_ready_3", 32'(req_ready), 32'd1);
        push(1'b0, 32'h10, 32'h0);
        chk("full_ready_4", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_mode  = 1'b1;
        req_addr  = 32'h50;
        req_wdata = 32'h77;
        step();
        step();
        req_valid = 1'b0;
        chk("full_ready_hold", 32'(req_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        drain_exp[0] = 32'hDEADBEEF;
        drain_exp[1] = 32'h55;
        drain_exp[2] = 32'h1234;
        drain_exp[3] = 32'h99;
        drain_exp[4] = 32'hDEADBEEF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp();
            chk("drain_data", rsp_data, drain_exp[i]);
            step();
        end
        wait_idle();
        chk("drain_ready", 32'(req_ready), 32'd1);
        chk("drain_last_addr", mem_address, 32'h10);
        chk("drain_last_mode", 32'(mem_mode), 32'd0);
        chk("drain_no_extra_wr", ram[8'h50], 32'h0);

        // reset while in CAPTURE with two entries queued
        push(1'b0, 32'h20, 32'h0);                      // E
        push(1'b1, 32'h60, 32'hAA);                     // E+1
        push(1'b1, 32'h70, 32'hBB);                     // E+2: now in CAPTURE
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_count", 32'(dut.count), 32'd0);
        chk("mrst_req_ready", 32'(req_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mrst_no_issue", 32'(mem_mode), 32'd0);
        end
        chk("mrst_no_wr60", ram[8'h60], 32'h0);
        chk("mrst_no_wr70", ram[8'h70], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
